jzjpcc_sram_arbiter: RTL and testbench

// - Shares one port of jzjpcc_inferred_sram between instruction fetch and the load/store (memory) stage.
// - Arbitrates, forms byte write masks and lane-replicated store data, and aligns/sign-extends load data.
// - Flags misaligned or illegal accesses.
// - Sits between the fetch/memory pipeline stages and the SRAM port. 1-cycle SRAM read latency.

---
 rtl/jzjpcc_pkg.sv | 26 ++
 rtl/jzjpcc_load_align.sv | 45 ++++
 rtl/jzjpcc_sram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_jzjpcc_sram_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/jzjpcc_pkg.sv
// ============================================================================
// Module : jzjpcc_pkg
// Brief  : Shared funct3 codes, response-owner states and arbiter defaults.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package jzjpcc_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH_RSP = 2'd1,
        DATA_RSP  = 2'd2
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/jzjpcc_load_align.sv
// ============================================================================
// Module : jzjpcc_load_align
// Brief  : Selects a byte/half/word from an SRAM word and sign/zero-extends it.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module jzjpcc_load_align
    import jzjpcc_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/jzjpcc_sram_arbiter.sv
// ============================================================================
// Module : jzjpcc_sram_arbiter
// Brief  : Shares one SRAM port between fetch and load/store with starvation guard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module jzjpcc_sram_arbiter
    import jzjpcc_pkg::*;
#(
    parameter int ADDR_WIDTH   = 30,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [31:0]           fetch_data,
    output logic                  fetch_error,
    input  logic                  data_req,
    input  logic                  data_write,
    input  logic [2:0]            data_funct3,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           data_wdata,
    output logic                  data_ready,
    output logic                  data_valid,
    output logic [31:0]           data_rdata,
    output logic                  data_error,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [31:0]           sram_write_data,
    output logic                  sram_write_enable,
    output logic [3:0]            sram_byte_mask,
    input  logic [31:0]           sram_read_data
);

    localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

    owner_t                r_owner;
    owner_t                w_owner_next;
    logic [3:0]            r_starve_cnt;
    logic [2:0]            r_funct3;
    logic [1:0]            r_offset;
    logic                  r_error;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_last_addr;

    logic                  w_fetch_grant;
    logic                  w_data_grant;
    logic                  w_fetch_err;
    logic                  w_data_err;
    logic [31:0]           w_load_data;

    // Data wins unless fetch has been denied STARVE_LIMIT cycles in a row.
    assign w_fetch_grant = !reset && fetch_req && (!data_req || (r_starve_cnt == c_limit));
    assign w_data_grant  = !reset && data_req && !w_fetch_grant;
    assign fetch_ready   = w_fetch_grant;
    assign data_ready    = w_data_grant;

    assign w_fetch_err = |fetch_addr[1:0];

    always_comb begin
        w_data_err = 1'b0;
        case (data_funct3)
            F3_B, F3_BU: w_data_err = data_write && data_funct3[2];
            F3_H, F3_HU: w_data_err = data_addr[0] || (data_write && data_funct3[2]);
            F3_W:        w_data_err = |data_addr[1:0];
            default:     w_data_err = 1'b1;
        endcase
    end

    always_comb begin
        sram_write_enable = 1'b0;
        sram_byte_mask    = 4'b0000;
        sram_write_data   = 32'd0;
        if (w_data_grant && data_write && !w_data_err) begin
            sram_write_enable = 1'b1;
            case (data_funct3[1:0])
                2'b00: begin
                    sram_byte_mask  = 4'b0001 << data_addr[1:0];
                    sram_write_data = {4{data_wdata[7:0]}};
                end
                2'b01: begin
                    sram_byte_mask  = 4'b0011 << data_addr[1:0];
                    sram_write_data = {2{data_wdata[15:0]}};
                end
                default: begin
                    sram_byte_mask  = 4'b1111;
                    sram_write_data = data_wdata;
                end
            endcase
        end
    end

    always_comb begin
        sram_address = r_last_addr;
        if (reset)
            sram_address = '0;
        else if (w_fetch_grant)
            sram_address = fetch_addr[ADDR_WIDTH+1:2];
        else if (w_data_grant)
            sram_address = data_addr[ADDR_WIDTH+1:2];
    end

    always_comb begin
        w_owner_next = IDLE;
        if (w_fetch_grant)
            w_owner_next = FETCH_RSP;
        else if (w_data_grant)
            w_owner_next = DATA_RSP;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner      <= IDLE;
            r_starve_cnt <= 4'd0;
            r_funct3     <= 3'd0;
            r_offset     <= 2'd0;
            r_error      <= 1'b0;
            r_write      <= 1'b0;
            r_last_addr  <= '0;
        end else begin
            r_owner     <= w_owner_next;
            r_last_addr <= sram_address;
            if (!fetch_req || w_fetch_grant)
                r_starve_cnt <= 4'd0;
            else
                r_starve_cnt <= r_starve_cnt + 4'd1;
            if (w_fetch_grant) begin
                r_funct3 <= F3_W;
                r_offset <= fetch_addr[1:0];
                r_error  <= w_fetch_err;
                r_write  <= 1'b0;
            end else if (w_data_grant) begin
                r_funct3 <= data_funct3;
                r_offset <= data_addr[1:0];
                r_error  <= w_data_err;
                r_write  <= data_write;
            end
        end
    end

    jzjpcc_load_align u_load_align (
        .i_word   (sram_read_data),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    // Responses are gated by reset so a pending one never leaks out.
    assign fetch_valid = !reset && (r_owner == FETCH_RSP);
    assign fetch_error = fetch_valid && r_error;
    assign fetch_data  = (fetch_valid && !r_error) ? sram_read_data : 32'd0;
    assign data_valid  = !reset && (r_owner == DATA_RSP);
    assign data_error  = data_valid && r_error;
    assign data_rdata  = (data_valid && !r_error && !r_write) ? w_load_data : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_jzjpcc_sram_arbiter.sv
// ============================================================================
// Module : tb_jzjpcc_sram_arbiter
// Brief  : Directed table-driven bench for jzjpcc_sram_arbiter with SRAM model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_jzjpcc_sram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready, fetch_valid, fetch_error;
    logic [31:0] fetch_data;
    logic        data_req, data_write;
    logic [2:0]  data_funct3;
    logic [31:0] data_addr, data_wdata;
    logic        data_ready, data_valid, data_error;
    logic [31:0] data_rdata;
    logic [29:0] sram_address;
    logic [31:0] sram_write_data;
    logic        sram_write_enable;
    logic [3:0]  sram_byte_mask;
    logic [31:0] sram_read_data;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [16];

    always #5 clock = ~clock;

    jzjpcc_sram_arbiter #(.ADDR_WIDTH(30), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_error(fetch_error),
        .data_req(data_req), .data_write(data_write), .data_funct3(data_funct3),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_ready(data_ready),
        .data_valid(data_valid), .data_rdata(data_rdata), .data_error(data_error),
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_write_enable(sram_write_enable), .sram_byte_mask(sram_byte_mask),
        .sram_read_data(sram_read_data)
    );

    // Behavioural SRAM: byte-masked write, one-cycle registered read.
    always @(posedge clock) begin
        if (sram_write_enable) begin
            for (int b = 0; b < 4; b++)
                if (sram_byte_mask[b])
                    mem[sram_address[3:0]][b*8 +: 8] <= sram_write_data[b*8 +: 8];
        end
        sram_read_data <= mem[sram_address[3:0]];
    end

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        dr;
        logic        dw;
        logic [2:0]  f3;
        logic [31:0] da;
        logic [31:0] wd;
        logic        e_fr;
        logic        e_dr;
        logic        e_we;
        logic [3:0]  e_mask;
        logic [31:0] e_wd;
        logic [29:0] e_addr;
        logic        e_fv;
        logic [31:0] e_fd;
        logic        e_fe;
        logic        e_dv;
        logic [31:0] e_dd;
        logic        e_de;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                         input logic [2:0] f3, input logic [31:0] da, input logic [31:0] wd);
        fetch_req   = fr;
        fetch_addr  = fa;
        data_req    = dr;
        data_write  = dw;
        data_funct3 = f3;
        data_addr   = da;
        data_wdata  = wd;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[0] = 32'h00000013;
        mem[1] = 32'hDEADBEEF;

        //          fr    fa         dr    dw    f3     da         wd            fr    dr    we    mask     wd             addr    fv    fd            fe    dv    dd            de
        vecs[0]  = '{1'b1, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        30'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h4, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        30'd1, 1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd0, 32'h6, 32'h000000F0, 1'b0, 1'b1, 1'b1, 4'b0100, 32'hF0F0F0F0, 30'd1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 32'h6, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 3'd4, 32'h6, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFF0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 3'd2, 32'h2, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h000000F0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd1, 32'h1, 32'h00001234, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h3, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        30'd0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 3'd3, 32'h4, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd4, 32'h8, 32'h00000055, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd2, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd1, 32'h6, 32'h0000ABCD, 1'b0, 1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 30'd1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 3'd1, 32'h6, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 3'd5, 32'h2, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFABCD, 1'b0};
        vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd2, 32'h8, 32'h11223344, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h11223344, 30'd2, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b0, 3'd2, 32'h8, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd2, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        30'd2, 1'b0, 32'h0,        1'b0, 1'b1, 32'h11223344, 1'b0};
        vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 32'h7, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        30'd1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFAB, 1'b0};
        vecs[18] = '{1'b0, 32'h0, 1'b1, 1'b0, 3'd1, 32'h4, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        30'd1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        vecs[19] = '{1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        30'd1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFBEEF, 1'b0};

        reset = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 1'b1, 3'd2, 32'h0, 32'hFFFFFFFF);
        repeat (3) @(negedge clock);
        #1;
        chk("rst_fready", {31'd0, fetch_ready}, 32'd0);
        chk("rst_dready", {31'd0, data_ready}, 32'd0);
        chk("rst_we", {31'd0, sram_write_enable}, 32'd0);
        chk("rst_valids", {30'd0, fetch_valid, data_valid}, 32'd0);
        chk("rst_rdata", data_rdata, 32'd0);

        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        chk("post_rst_valids", {30'd0, fetch_valid, data_valid}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            drive(vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].dw, vecs[i].f3, vecs[i].da, vecs[i].wd);
            #1;
            chk($sformatf("v%0d fetch_ready", i), {31'd0, fetch_ready}, {31'd0, vecs[i].e_fr});
            chk($sformatf("v%0d data_ready", i), {31'd0, data_ready}, {31'd0, vecs[i].e_dr});
            chk($sformatf("v%0d write_enable", i), {31'd0, sram_write_enable}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d byte_mask", i), {28'd0, sram_byte_mask}, {28'd0, vecs[i].e_mask});
            chk($sformatf("v%0d write_data", i), sram_write_data, vecs[i].e_wd);
            chk($sformatf("v%0d address", i), {2'd0, sram_address}, {2'd0, vecs[i].e_addr});
            chk($sformatf("v%0d fetch_valid", i), {31'd0, fetch_valid}, {31'd0, vecs[i].e_fv});
            chk($sformatf("v%0d fetch_data", i), fetch_data, vecs[i].e_fd);
            chk($sformatf("v%0d fetch_error", i), {31'd0, fetch_error}, {31'd0, vecs[i].e_fe});
            chk($sformatf("v%0d data_valid", i), {31'd0, data_valid}, {31'd0, vecs[i].e_dv});
            chk($sformatf("v%0d data_rdata", i), data_rdata, vecs[i].e_dd);
            chk($sformatf("v%0d data_error", i), {31'd0, data_error}, {31'd0, vecs[i].e_de});
        end

        // Starvation: fetch must win on the fifth contested cycle, then data again.
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            drive(1'b1, 32'h4, 1'b1, 1'b0, 3'd2, 32'h8, 32'h0);
            #1;
            chk($sformatf("starve%0d fetch_ready", k), {31'd0, fetch_ready}, (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("starve%0d data_ready", k), {31'd0, data_ready}, (k == 4) ? 32'd0 : 32'd1);
            if (k >= 1 && k <= 4)
                chk($sformatf("starve%0d data_rdata", k), data_rdata, 32'h11223344);
        end
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        chk("starve fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("starve data_valid", {31'd0, data_valid}, 32'd1);

        // Reset mid-operation with starve count already at 2.
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            drive(1'b1, 32'h0, 1'b1, 1'b0, 3'd2, 32'h8, 32'h0);
            #1;
            chk($sformatf("pre_rst%0d data_ready", k), {31'd0, data_ready}, 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            reset = 1'b1;
            #1;
            chk($sformatf("mid_rst%0d data_valid", k), {31'd0, data_valid}, 32'd0);
            chk($sformatf("mid_rst%0d readies", k), {30'd0, fetch_ready, data_ready}, 32'd0);
            chk($sformatf("mid_rst%0d data_rdata", k), data_rdata, 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            reset = 1'b0;
            #1;
            if (k == 0)
                chk("after_rst data_valid", {31'd0, data_valid}, 32'd0);
            chk($sformatf("after_rst%0d fetch_ready", k), {31'd0, fetch_ready}, (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("after_rst%0d data_ready", k), {31'd0, data_ready}, (k == 4) ? 32'd0 : 32'd1);
        end

        @(negedge clock);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        chk("final fetch_valid", {31'd0, fetch_valid}, 32'd1);
        chk("final fetch_data", fetch_data, 32'h00000013);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
